cru_readback: RTL and testbench

Clock-domain CRU read responder for the TI-99/4A expansion bus, the input-direction companion of the CRU output latch. It samples the asynchronous TI address, MEMEN and CRUCLK signals into the CPLD clock domain, decodes CRU reads aimed at this card's base, and drives the CRUIN bit with either loopback output bits or sticky event flags. Sticky flags are raised by asynchronous event inputs and cleared by CPU CRU writes of 0 to the flag's bit.

---
 rtl/cru_readback.sv | 116 +++++++++++
 tb/tb_cru_readback.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cru_readback.sv
// CRU read responder: synchronizes TI bus/event inputs, answers CRU reads with
// loopback bits or sticky event flags, and clears flags on CRU writes of 0.
module cru_readback #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:3]  cru_base,
    input  logic [0:14] addr,
    input  logic        memen_n,
    input  logic        cru_clk,
    input  logic        cru_in,
    input  logic [0:3]  loop_bits,
    input  logic [0:3]  evt,
    output logic        cru_out,
    output logic        cru_oe,
    output logic [0:3]  flags
);

    localparam int unsigned AW = 15;
    localparam int unsigned NF = 4;
    localparam int unsigned SW = AW + 3 + NF;
    // Bit layout: {addr, memen_n, cru_clk, cru_in, evt}; memen_n chain idles high
    localparam logic [SW-1:0] SYNC_RST = SW'(64);

    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_last;

    logic [0:AW-1] addr_s;
    logic          memen_n_s;
    logic          cru_clk_s;
    logic          cru_in_s;
    logic [0:NF-1] evt_s;

    logic          cru_clk_prev_q;
    logic [0:NF-1] evt_prev_q;
    logic [0:NF-1] flags_q, flags_d;
    logic          cru_out_q, cru_out_d;
    logic          cru_oe_q, cru_oe_d;

    logic          match;
    logic [2:0]    idx;
    logic          clk_fall;
    logic          clr_en;
    logic [0:NF-1] evt_rise;

    // Input synchronizer chain for every asynchronous TI-side and event input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= SYNC_RST;
            end
        end else begin
            sync_q[0] <= {addr, memen_n, cru_clk, cru_in, evt};
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign addr_s    = sync_last[SW-1:NF+3];
    assign memen_n_s = sync_last[NF+2];
    assign cru_clk_s = sync_last[NF+1];
    assign cru_in_s  = sync_last[NF];
    assign evt_s     = sync_last[NF-1:0];

    assign idx      = addr_s[12:14];
    assign match    = (addr_s[0:3] == 4'b0001) && (addr_s[4:7] == cru_base)
                      && (addr_s[8:11] == 4'b0000);
    assign clk_fall = cru_clk_prev_q && !cru_clk_s;
    assign clr_en   = clk_fall && match && idx[2] && !cru_in_s;
    assign evt_rise = evt_s & ~evt_prev_q;

    // Flag update: clear first so a coincident rising edge wins
    always_comb begin
        flags_d = flags_q;
        for (int unsigned i = 0; i < NF; i++) begin
            if (clr_en && (idx[1:0] == 2'(i))) begin
                flags_d[i] = 1'b0;
            end
            if (evt_rise[i]) begin
                flags_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cru_oe_d  = match && memen_n_s;
        cru_out_d = 1'b0;
        if (cru_oe_d) begin
            cru_out_d = idx[2] ? flags_q[idx[1:0]] : loop_bits[idx[1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cru_clk_prev_q <= 1'b0;
            evt_prev_q     <= '0;
            flags_q        <= '0;
            cru_out_q      <= 1'b0;
            cru_oe_q       <= 1'b0;
        end else begin
            cru_clk_prev_q <= cru_clk_s;
            evt_prev_q     <= evt_s;
            flags_q        <= flags_d;
            cru_out_q      <= cru_out_d;
            cru_oe_q       <= cru_oe_d;
        end
    end

    assign cru_out = cru_out_q;
    assign cru_oe  = cru_oe_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_cru_readback.sv
// Directed self-checking bench for cru_readback with SYNC_STAGES=2.
module tb_cru_readback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:3]  cru_base;
    logic [0:14] addr;
    logic        memen_n;
    logic        cru_clk;
    logic        cru_in;
    logic [0:3]  loop_bits;
    logic [0:3]  evt;
    logic        cru_out;
    logic        cru_oe;
    logic [0:3]  flags;

    int errors = 0;
    int checks = 0;

    cru_readback #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cru_base (cru_base),
        .addr     (addr),
        .memen_n  (memen_n),
        .cru_clk  (cru_clk),
        .cru_in   (cru_in),
        .loop_bits(loop_bits),
        .evt      (evt),
        .cru_out  (cru_out),
        .cru_oe   (cru_oe),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    function automatic logic [0:14] mk(input logic [3:0] base, input logic [2:0] idx);
        return {4'b0001, base, 4'b0000, idx};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Pulse cru_clk low for a full write cycle with addr/cru_in already settled
    task automatic cru_write(input logic [0:14] a, input logic d);
        addr = a; cru_in = d;
        tick(3);
        cru_clk = 1'b0;
        tick(3);
        cru_clk = 1'b1;
        tick(3);
    endtask

    initial begin
        rst_n = 1'b0; cru_base = 4'h2; addr = mk(4'h2, 3'd0); memen_n = 1'b1;
        cru_clk = 1'b1; cru_in = 1'b1; loop_bits = 4'b1010; evt = 4'b0000;
        tick(3);
        check("reset_oe", {3'b0, cru_oe}, 4'h0);
        check("reset_out", {3'b0, cru_out}, 4'h0);
        check("reset_flags", flags, 4'b0000);

        rst_n = 1'b1;
        tick(2);
        check("release_oe_early", {3'b0, cru_oe}, 4'h0);
        tick(1);
        check("release_oe_3clk", {3'b0, cru_oe}, 4'h1);

        // Loopback reads, loop_bits=1010 -> bits 1,0,1,0
        addr = mk(4'h2, 3'd0); tick(3);
        check("loop0_out", {3'b0, cru_out}, 4'h1);
        check("loop0_oe", {3'b0, cru_oe}, 4'h1);
        addr = mk(4'h2, 3'd1); tick(3);
        check("loop1_out", {3'b0, cru_out}, 4'h0);
        addr = mk(4'h2, 3'd2); tick(3);
        check("loop2_out", {3'b0, cru_out}, 4'h1);
        addr = mk(4'h2, 3'd3); tick(3);
        check("loop3_out", {3'b0, cru_out}, 4'h0);
        check("loop3_oe", {3'b0, cru_oe}, 4'h1);
        memen_n = 1'b0; addr = mk(4'h2, 3'd0); tick(3);
        check("memen_low_oe", {3'b0, cru_oe}, 4'h0);
        check("memen_low_out", {3'b0, cru_out}, 4'h0);
        memen_n = 1'b1;

        // Event set on evt[2]
        evt = 4'b0010;
        tick(2);
        check("evt_set_early", flags, 4'b0000);
        tick(1);
        check("evt_set", flags, 4'b0010);
        evt = 4'b0000;
        addr = mk(4'h2, 3'd6); tick(3);
        check("read_idx6_out", {3'b0, cru_out}, 4'h1);
        check("read_idx6_oe", {3'b0, cru_oe}, 4'h1);
        addr = mk(4'h2, 3'd5); tick(3);
        check("read_idx5_out", {3'b0, cru_out}, 4'h0);

        // Clear flag 2 by writing 0 to index 6 during a sustained read
        addr = mk(4'h2, 3'd6); cru_in = 1'b0; tick(3);
        cru_clk = 1'b0;
        tick(2);
        check("clr_early", flags, 4'b0010);
        tick(1);
        check("clr_flag2", flags, 4'b0000);
        tick(1);
        check("clr_out_tracks", {3'b0, cru_out}, 4'h0);
        cru_clk = 1'b1; tick(3);

        evt = 4'b0010; tick(3); evt = 4'b0000; tick(1);
        check("reset_flag2", flags, 4'b0010);
        cru_write(mk(4'h2, 3'd6), 1'b1);
        check("write1_noeffect", flags, 4'b0010);
        cru_write(mk(4'h3, 3'd6), 1'b0);
        check("wrong_base_flags", flags, 4'b0010);
        check("wrong_base_oe", {3'b0, cru_oe}, 4'h0);
        cru_write(mk(4'h2, 3'd2), 1'b0);
        check("write_idx2_ignored", flags, 4'b0010);

        // Set/clear collision on flag 0: set wins
        addr = mk(4'h2, 3'd4); cru_in = 1'b0; tick(3);
        evt = 4'b1000; cru_clk = 1'b0;
        tick(3);
        check("collision_set_wins", flags, 4'b1010);
        cru_clk = 1'b1; evt = 4'b0000; tick(3);
        cru_write(mk(4'h2, 3'd4), 1'b0);
        check("clr_flag0", flags, 4'b0010);

        // Held-high evt does not re-set after clear
        evt = 4'b0100; tick(3);
        check("evt1_set", flags, 4'b0110);
        cru_write(mk(4'h2, 3'd5), 1'b0);
        check("evt1_cleared", flags, 4'b0010);
        tick(3);
        check("evt1_held_no_reset", flags, 4'b0010);
        evt = 4'b0000;

        // Non-matching addresses
        addr = {4'b0001, 4'h2, 4'b0001, 3'b000}; tick(3);
        check("nomatch_idx8_oe", {3'b0, cru_oe}, 4'h0);
        addr = {4'b0000, 4'h2, 4'b0000, 3'b000}; tick(3);
        check("nomatch_hi_oe", {3'b0, cru_oe}, 4'h0);

        // Async reset mid-read
        addr = mk(4'h2, 3'd0); tick(3);
        check("preread_oe", {3'b0, cru_oe}, 4'h1);
        check("preread_out", {3'b0, cru_out}, 4'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_oe", {3'b0, cru_oe}, 4'h0);
        check("midreset_out", {3'b0, cru_out}, 4'h0);
        check("midreset_flags", flags, 4'b0000);

        // evt high across reset release counts as a rising edge
        evt = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check("evt_at_release_early", flags, 4'b0000);
        tick(1);
        check("evt_at_release", flags, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
